siso_input_buffer: RTL and testbench

- Upstream stage of the SISO decoder core.
- Collects one code block of interleaved systematic/parity LLR words plus a-priori LLRs into an internal tuple RAM.
- Once the block is complete, replays it to the core twice: first in reverse order for the backward (beta) recursion, then in forward order for the alpha/LLR pass.
- Decouples the free-running input stream from the core's two-pass access pattern.

---
 rtl/siso_input_buffer.sv | 183 ++++++++++++++++++
 tb/tb_siso_input_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/siso_input_buffer.sv
// siso_input_buffer
//   Upstream stage of the SISO decoder core. Collects one code block of
//   interleaved systematic/parity LLR words plus a-priori LLRs into an
//   internal tuple RAM. It then replays the block twice with no bubble:
//   first in reverse order (backward/beta pass), then in forward order
//   (alpha/LLR pass).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   blklen            block length in tuples (1..MAX_BLK), qualified by valid_blklen
//   in, valid_in      LLR stream: even words systematic, odd words parity
//   apriori,
//   valid_apriori     a-priori LLR for the tuple being loaded
//   sys_o/par_o/apr_o replayed tuple, qualified by valid_o
//   bwd_o             1 = backward pass, 0 = forward pass
//   last_o            final tuple of the current pass
//   busy              high whenever not IDLE
//   done              1-cycle pulse after the last forward tuple
//   err               sticky: [0] bad blklen, [1] stray input, [2] missing a-priori
module siso_input_buffer #(
  parameter int W       = 16,
  parameter int MAX_BLK = 6144,
  parameter int AW      = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   blklen,
  input  logic          valid_blklen,
  input  logic [W-1:0]  in,
  input  logic          valid_in,
  input  logic [W-1:0]  apriori,
  input  logic          valid_apriori,
  output logic [W-1:0]  sys_o,
  output logic [W-1:0]  par_o,
  output logic [W-1:0]  apr_o,
  output logic          valid_o,
  output logic          bwd_o,
  output logic          last_o,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BWD, S_FWD} state_t;

  state_t           r_state, w_state_nxt;

  logic [AW-1:0]    r_nm1;        // block length minus one
  logic [AW-1:0]    r_k;          // load write address
  logic [AW-1:0]    r_ra;         // replay read address
  logic             r_half;
  logic [W-1:0]     r_sys;
  logic [W-1:0]     r_apr;
  logic             r_apr_seen;
  logic             r_fwd_end;    // last forward read already issued
  logic             r_vld;
  logic             r_bwd;
  logic             r_last;
  logic             r_done;
  logic [2:0]       r_err;

  logic [3*W-1:0]   r_mem [MAX_BLK];
  logic [3*W-1:0]   r_rd;

  logic             w_blk_ok;
  logic             w_we;
  logic [W-1:0]     w_apr_wr;
  logic             w_apr_miss;
  logic             w_re;
  logic             w_rd_last;
  logic             w_fwd_out_last;

  always_comb begin
    w_blk_ok       = valid_blklen && (blklen != 16'd0) && (32'(blklen) <= MAX_BLK);
    w_we           = (r_state == S_LOAD) && valid_in && r_half;
    w_apr_wr       = valid_apriori ? apriori : (r_apr_seen ? r_apr : '0);
    w_apr_miss     = w_we && !valid_apriori && !r_apr_seen;
    w_re           = (r_state == S_BWD) || ((r_state == S_FWD) && !r_fwd_end);
    w_rd_last      = (r_state == S_BWD) ? (r_ra == '0) : (r_ra == r_nm1);
    // FWD is held until the final forward tuple has left the read register,
    // so busy stays high through the last output and done follows it.
    w_fwd_out_last = r_vld && r_last && !r_bwd;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_blk_ok)                 w_state_nxt = S_LOAD;
      S_LOAD:  if (w_we && (r_k == r_nm1))   w_state_nxt = S_BWD;
      S_BWD:   if (r_ra == '0)               w_state_nxt = S_FWD;
      S_FWD:   if (w_fwd_out_last)           w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nm1      <= '0;
      r_k        <= '0;
      r_ra       <= '0;
      r_half     <= 1'b0;
      r_sys      <= '0;
      r_apr      <= '0;
      r_apr_seen <= 1'b0;
      r_fwd_end  <= 1'b0;
      r_vld      <= 1'b0;
      r_bwd      <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
    end else begin
      if (valid_blklen && (r_state == S_IDLE) && !w_blk_ok) r_err[0] <= 1'b1;
      if (valid_in && (r_state != S_LOAD))                  r_err[1] <= 1'b1;
      if (w_apr_miss)                                       r_err[2] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_blk_ok) begin
            r_nm1      <= AW'(blklen - 16'd1);
            r_k        <= '0;
            r_half     <= 1'b0;
            r_apr_seen <= 1'b0;
          end
        end
        S_LOAD: begin
          if (valid_apriori) r_apr <= apriori;
          if (w_we)               r_apr_seen <= 1'b0;
          else if (valid_apriori) r_apr_seen <= 1'b1;
          if (valid_in) begin
            r_half <= ~r_half;
            if (!r_half) r_sys <= in;
          end
          if (w_we) begin
            if (r_k == r_nm1) begin
              r_ra      <= r_nm1;
              r_fwd_end <= 1'b0;
            end else begin
              r_k <= r_k + AW'(1);
            end
          end
        end
        S_BWD: begin
          if (r_ra != '0) r_ra <= r_ra - AW'(1);
        end
        S_FWD: begin
          if (w_re) begin
            if (r_ra == r_nm1) r_fwd_end <= 1'b1;
            else               r_ra      <= r_ra + AW'(1);
          end
        end
        default: ;
      endcase

      r_vld  <= w_re;
      r_bwd  <= (r_state == S_BWD);
      r_last <= w_re && w_rd_last;
      r_done <= (r_state == S_FWD) && w_fwd_out_last;
    end
  end

  // Tuple RAM: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_k] <= {r_sys, in, w_apr_wr};
    if (w_re) r_rd <= r_mem[r_ra];
  end

  // Read data is undefined until the first replay; gate it with valid.
  assign sys_o   = r_vld ? r_rd[3*W-1:2*W] : '0;
  assign par_o   = r_vld ? r_rd[2*W-1:W]   : '0;
  assign apr_o   = r_vld ? r_rd[W-1:0]     : '0;
  assign valid_o = r_vld;
  assign bwd_o   = r_vld & r_bwd;
  assign last_o  = r_vld & r_last;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_siso_input_buffer.sv
// Directed bench for siso_input_buffer: loads blocks, checks the backward
// then forward replay tuple by tuple, plus error flags and mid-load reset.
module tb_siso_input_buffer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   blklen;
  logic          valid_blklen;
  logic [W-1:0]  in;
  logic          valid_in;
  logic [W-1:0]  apriori;
  logic          valid_apriori;
  logic [W-1:0]  sys_o, par_o, apr_o;
  logic          valid_o, bwd_o, last_o, busy, done;
  logic [2:0]    err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sys [512];
  logic [W-1:0] exp_par [512];
  logic [W-1:0] exp_apr [512];

  siso_input_buffer #(.W(16), .MAX_BLK(6144), .AW(13)) dut (
    .clk(clk), .rst(rst),
    .blklen(blklen), .valid_blklen(valid_blklen),
    .in(in), .valid_in(valid_in),
    .apriori(apriori), .valid_apriori(valid_apriori),
    .sys_o(sys_o), .par_o(par_o), .apr_o(apr_o),
    .valid_o(valid_o), .bwd_o(bwd_o), .last_o(last_o),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends blklen n, then 'pairs' sys/par pairs; a-priori rides with the sys
  // word except for pair index no_apr. Returns at the negedge after the
  // last parity word was consumed.
  task automatic send_block(input int n, input int pairs, input int no_apr);
    @(negedge clk);
    blklen = 16'(n); valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
    chk("busy_load", 64'(busy), 64'd1);
    for (int i = 0; i < pairs; i++) begin
      in = exp_sys[i]; valid_in = 1'b1;
      apriori = exp_apr[i]; valid_apriori = (i != no_apr);
      @(negedge clk);
      in = exp_par[i]; valid_apriori = 1'b0;
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  // Checks 2n replay tuples starting 2 cycles after the last parity word;
  // optionally pulses valid_in at replay cycle 'inject'.
  task automatic check_replay(input int n, input int inject, input string tag);
    logic [63:0] e;
    logic [63:0] o;
    int idx;
    chk({tag, "_lat"}, 64'(valid_o), 64'd0);
    @(negedge clk);
    for (int j = 0; j < 2*n; j++) begin
      idx = (j < n) ? (n - 1 - j) : (j - n);
      e = {13'd0, 1'b1, (j < n), ((j == n-1) || (j == 2*n-1)),
           exp_sys[idx], exp_par[idx], exp_apr[idx]};
      o = {13'd0, valid_o, bwd_o, last_o, sys_o, par_o, apr_o};
      chk(tag, o, e);
      if (j == inject) begin valid_in = 1'b1; in = 16'hDEAD; end
      else valid_in = 1'b0;
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk({tag, "_done"}, 64'({valid_o, done, busy}), 64'b010);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({valid_o, done, busy}), 64'b000);
  endtask

  initial begin
    rst = 1'b1; blklen = '0; valid_blklen = 1'b0; in = '0; valid_in = 1'b0;
    apriori = '0; valid_apriori = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({sys_o, par_o, apr_o, valid_o, bwd_o, last_o, busy, done, err}), 64'd0);
    rst = 1'b0;

    // 512-tuple block
    for (int i = 0; i < 512; i++) begin
      exp_sys[i] = 16'(i); exp_par[i] = 16'(1000 + i); exp_apr[i] = 16'(i);
    end
    send_block(512, 512, -1);
    check_replay(512, -1, "blk512");
    chk("err_blk512", 64'(err), 64'd0);

    // N = 1
    exp_sys[0] = 16'd7; exp_par[0] = 16'hFFFD; exp_apr[0] = 16'd5;
    send_block(1, 1, -1);
    check_replay(1, -1, "blk1");

    // bad lengths
    @(negedge clk); blklen = 16'd0; valid_blklen = 1'b1;
    @(negedge clk); valid_blklen = 1'b0;
    chk("bad0_busy_err", 64'({busy, err}), 64'b0001);
    @(negedge clk); blklen = 16'd7000; valid_blklen = 1'b1;
    @(negedge clk); valid_blklen = 1'b0;
    chk("bad7000_busy_err", 64'({busy, err}), 64'b0001);
    for (int i = 0; i < 4; i++) begin
      exp_sys[i] = 16'(300 + i); exp_par[i] = 16'(16'hF000 + i); exp_apr[i] = 16'(50 - i);
    end
    send_block(4, 4, -1);
    check_replay(4, -1, "blk4");
    chk("err_after4", 64'(err), 64'b001);

    // missing a-priori on pair 3
    for (int i = 0; i < 8; i++) begin
      exp_sys[i] = 16'(40 + i); exp_par[i] = 16'(80 + i); exp_apr[i] = 16'(100 + i);
    end
    send_block(8, 8, 3);
    exp_apr[3] = 16'd0;
    check_replay(8, -1, "blk8");
    chk("err_noapr", 64'(err), 64'b101);

    // stray input during BWD
    for (int i = 0; i < 4; i++) begin
      exp_sys[i] = 16'(16'h1111 * (i + 1)); exp_par[i] = 16'(16'h0101 * (i + 2)); exp_apr[i] = 16'(i + 9);
    end
    send_block(4, 4, -1);
    check_replay(4, 1, "stray_bwd");
    chk("err_stray_bwd", 64'(err), 64'b111);

    // reset mid-load
    for (int i = 0; i < 512; i++) begin
      exp_sys[i] = 16'(9000 + i); exp_par[i] = 16'(7000 + i); exp_apr[i] = 16'(3000 + i);
    end
    send_block(512, 300, -1);
    #2 rst = 1'b1;
    #1 chk("rst_mid", 64'({valid_o, done, busy, err}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // stray input in IDLE
    @(negedge clk); valid_in = 1'b1; in = 16'hBEEF;
    @(negedge clk); valid_in = 1'b0;
    chk("err_stray_idle", 64'({busy, err}), 64'b0010);

    for (int i = 0; i < 16; i++) begin
      exp_sys[i] = 16'(2000 + i); exp_par[i] = 16'(16'h8000 + i); exp_apr[i] = 16'(16'hFFF0 + i);
    end
    send_block(16, 16, -1);
    check_replay(16, -1, "blk16");
    chk("err_final", 64'(err), 64'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
